// File: rtl/table_entry_fetcher_if.sv
// rtl/table_entry_fetcher_if.sv - request/entry stream bundle and 8-lane DRAM user port
// BUFFER_ENTRY is carried as {valid, entry[127:0]} in out_entry.
interface table_entry_fetcher_if #(parameter int CNT_W = 8);
  logic             req_valid;
  logic             req_ready;
  logic [63:0]      req_addr;
  logic [CNT_W-1:0] req_count;
  logic             out_valid;
  logic             out_ready;
  logic [128:0]     out_entry;
  logic             done;

  modport master (
    output req_valid, req_addr, req_count, out_ready,
    input  req_ready, out_valid, out_entry, done
  );
  modport slave (
    input  req_valid, req_addr, req_count, out_ready,
    output req_ready, out_valid, out_entry, done
  );
endinterface

interface dram_port_if;
  logic [7:0]       en;
  logic             rdwr;
  logic [7:0][63:0] addr;
  logic [7:0][7:0]  data;
  logic [7:0]       valid;

  modport user (output en, rdwr, addr, input data, valid);
  modport mem  (input en, rdwr, addr, output data, valid);
endinterface

// File: rtl/table_entry_fetcher.sv
// rtl/table_entry_fetcher.sv - reads a run of 16-byte table entries over the 8-lane DRAM port
// Each entry takes two 8-byte beats; lanes may return out of order and are merged via got_q.
module table_entry_fetcher #(
  parameter int CNT_W = 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  table_entry_fetcher_if.slave fetch,
  dram_port_if.user            dram
);

  typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, OUT, DONE} state_t;

  state_t           state_q;
  logic             req_ready_q;
  logic             out_valid_q;
  logic             done_q;
  logic             en_q;
  logic [63:0]      lane_base_q;
  logic [63:0]      cur_addr_q;
  logic [CNT_W-1:0] remaining_q;
  logic [7:0]       got_q;
  logic [127:0]     entry_q;

  logic [63:0]      aligned_addr_d;
  logic [63:0]      next_addr_d;
  logic [7:0]       cap_d;
  logic             beat_done_d;

  assign aligned_addr_d = fetch.req_addr & ~64'hF;
  assign next_addr_d    = cur_addr_q + 64'd16;
  assign cap_d          = dram.valid & ~got_q;
  assign beat_done_d    = ((got_q | dram.valid) == 8'hFF);

  assign fetch.req_ready = req_ready_q;
  assign fetch.out_valid = out_valid_q;
  assign fetch.out_entry = {out_valid_q, entry_q};
  assign fetch.done      = done_q;

  assign dram.en   = {8{en_q}};
  assign dram.rdwr = 1'b0;

  always_comb begin
    dram.addr = '0;
    for (int i = 0; i < 8; i++) begin
      if (en_q) dram.addr[i] = lane_base_q + 64'(i);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      req_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      lane_base_q <= '0;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      got_q       <= '0;
      entry_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (fetch.req_valid) begin
            cur_addr_q  <= aligned_addr_d;
            remaining_q <= fetch.req_count;
            got_q       <= '0;
            req_ready_q <= 1'b0;
            if (fetch.req_count != '0) begin
              state_q     <= RD_LO;
              en_q        <= 1'b1;
              lane_base_q <= aligned_addr_d;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        RD_LO, RD_HI: begin
          // Only first arrival per lane is kept; repeats on captured lanes are dropped.
          for (int i = 0; i < 8; i++) begin
            if (cap_d[i]) begin
              if (state_q == RD_LO) entry_q[8*i +: 8] <= dram.data[i];
              else                  entry_q[64 + 8*i +: 8] <= dram.data[i];
            end
          end
          if (beat_done_d) begin
            got_q <= '0;
            if (state_q == RD_LO) begin
              state_q     <= RD_HI;
              lane_base_q <= cur_addr_q + 64'd8;
            end else begin
              state_q     <= OUT;
              en_q        <= 1'b0;
              lane_base_q <= '0;
              out_valid_q <= 1'b1;
            end
          end else begin
            got_q <= got_q | dram.valid;
          end
        end
        OUT: begin
          if (fetch.out_ready) begin
            out_valid_q <= 1'b0;
            if (remaining_q == CNT_W'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= RD_LO;
              cur_addr_q  <= next_addr_d;
              remaining_q <= remaining_q - CNT_W'(1);
              got_q       <= '0;
              en_q        <= 1'b1;
              lane_base_q <= next_addr_d;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_table_entry_fetcher.sv
// tb/tb_table_entry_fetcher.sv - randomized scoreboard bench for table_entry_fetcher
// Memory content is a pure function of address, so the reference entry follows from the base address alone.
module tb_table_entry_fetcher;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  table_entry_fetcher_if #(.CNT_W(CNT_W)) f();
  dram_port_if d();

  table_entry_fetcher #(.CNT_W(CNT_W)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .fetch   (f.slave),
    .dram    (d.user)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [128:0] exp_q[$];
  int done_cnt = 0;
  int hs_cnt = 0;
  bit en_seen = 1'b0;
  bit prev_done = 1'b0;
  int resp_mode = 0;   // 0 all lanes at once, 1 random lanes, 2 ragged order, 3 low beat only, 4 manual
  int rdy_mode = 0;    // 0 always ready, 1 random, 2 stall on second entry
  int stall_left = 0;
  int rag_seq[9] = '{7, 0, 7, 3, 1, 6, 2, 5, 4};
  int lat;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h10 ^ a[23:16] ^ a[31:24] ^
           a[39:32] ^ a[47:40] ^ a[55:48] ^ a[63:56];
  endfunction

  function automatic logic [127:0] model_entry(input logic [63:0] base);
    logic [127:0] e;
    for (int k = 0; k < 16; k++) e[8*k +: 8] = mem_byte(base + 64'(k));
    return e;
  endfunction

  task automatic check(input string name, input logic [128:0] act, input logic [128:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // DRAM responder: already-delivered lanes get corrupted data so an overwrite is visible.
  initial begin
    logic [63:0] prev_a0;
    logic [7:0]  dlv;
    logic [7:0]  v;
    int          ridx;
    prev_a0 = '0;
    dlv = '0;
    ridx = 0;
    forever begin
      @(posedge clk);
      #1;
      if (resp_mode != 4) begin
        if (d.en == 8'h00 || d.addr[0] != prev_a0) begin
          dlv = '0;
          ridx = 0;
        end
        prev_a0 = d.addr[0];
        v = '0;
        if (d.en != 8'h00) begin
          case (resp_mode)
            0: v = 8'hFF;
            1: v = 8'($urandom);
            2: begin
              if (ridx < 9) v = 8'(1) << rag_seq[ridx];
              ridx++;
            end
            3: v = d.addr[0][3] ? 8'h00 : 8'hFF;
            default: v = '0;
          endcase
        end
        for (int i = 0; i < 8; i++)
          d.data[i] = dlv[i] ? ~mem_byte(d.addr[i]) : mem_byte(d.addr[i]);
        dlv |= v;
        d.valid = v;
      end
    end
  end

  initial begin
    f.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: f.out_ready = 1'b1;
        1: f.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (f.out_valid && hs_cnt == 1 && stall_left > 0) begin
            f.out_ready = 1'b0;
            stall_left--;
          end else begin
            f.out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  // Monitor: out_entry must match the head of the queue on every valid cycle, not just at handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (d.en != 8'h00) begin
          en_seen = 1'b1;
          check("en_all_lanes", d.en, 8'hFF);
        end
        if (f.out_valid) begin
          check("en_low_in_out", d.en, 8'h00);
          if (exp_q.size() == 0) begin
            fail("unexpected_entry");
          end else begin
            check("out_entry", f.out_entry, exp_q[0]);
            if (f.out_ready) begin
              void'(exp_q.pop_front());
              hs_cnt++;
            end
          end
        end
        if (prev_done) check("ready_after_done", f.req_ready, 1'b1);
        if (f.done) begin
          done_cnt++;
          check("ready_low_in_done", f.req_ready, 1'b0);
        end
        prev_done = f.done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic issue(input logic [63:0] addr, input int cnt, output int latency);
    logic [63:0] base;
    int start_done;
    int guard;
    base = addr & ~64'hF;
    start_done = done_cnt;
    for (int e = 0; e < cnt; e++) exp_q.push_back({1'b1, model_entry(base + 64'(16 * e))});
    @(negedge clk);
    check("req_ready_idle", f.req_ready, 1'b1);
    f.req_valid = 1'b1;
    f.req_addr  = addr;
    f.req_count = CNT_W'(cnt);
    @(posedge clk);
    #1;
    f.req_valid = 1'b0;
    f.req_addr  = {$urandom, $urandom};
    f.req_count = CNT_W'($urandom);
    latency = 1;
    guard = 0;
    while (!f.out_valid && !f.done && guard < 2000) begin
      @(posedge clk);
      #1;
      latency++;
      guard++;
    end
    guard = 0;
    while (done_cnt == start_done && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    if (done_cnt == start_done) fail("done_timeout");
    repeat (3) @(negedge clk);
    check("done_once", done_cnt - start_done, 1);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    f.req_valid = 1'b0;
    f.req_addr  = '0;
    f.req_count = '0;
    d.valid = '0;
    d.data  = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", f.req_ready, 1'b1);
    check("rst_out_valid", f.out_valid, 1'b0);
    check("rst_out_entry", f.out_entry, '0);
    check("rst_done", f.done, 1'b0);
    check("rst_en", d.en, 8'h00);
    check("rst_rdwr", d.rdwr, 1'b0);
    check("rst_addr", |d.addr, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    resp_mode = 0; rdy_mode = 0;
    issue(64'h1000, 1, lat);
    check("lat_min", lat, 3);

    resp_mode = 2;
    issue(64'h3040, 1, lat);
    check("lat_ragged", lat, 19);

    resp_mode = 1; rdy_mode = 2; stall_left = 5; hs_cnt = 0;
    issue(64'h5000_0000_0000_1230, 3, lat);
    check("bp_handshakes", hs_cnt, 3);
    check("bp_stall_used", stall_left, 0);

    resp_mode = 0; rdy_mode = 0; en_seen = 1'b0;
    issue(64'h7777, 0, lat);
    check("cnt0_lat", lat, 1);
    check("cnt0_no_en", en_seen, 1'b0);

    issue(64'hFFFF_FFFF_FFFF_FFF0, 2, lat);

    resp_mode = 3;
    @(negedge clk);
    f.req_valid = 1'b1; f.req_addr = 64'h40; f.req_count = CNT_W'(1);
    @(posedge clk);
    #1;
    f.req_valid = 1'b0;
    guard = 0;
    while (!(d.en != 8'h00 && d.addr[0][3]) && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 50) fail("reach_rd_hi");
    #1;
    rst = 1'b1;
    #1;
    check("async_en_drop", d.en, 8'h00);
    check("async_out_valid", f.out_valid, 1'b0);
    check("async_req_ready", f.req_ready, 1'b1);
    exp_q.delete();
    resp_mode = 4;
    d.valid = 8'hFF;
    d.data  = {8{8'hA5}};
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      d.valid = ~d.valid;
    end
    check("late_valid_en", d.en, 8'h00);
    check("late_valid_out", f.out_valid, 1'b0);
    check("late_valid_ready", f.req_ready, 1'b1);
    d.valid = '0;
    resp_mode = 0;
    issue(64'h2F, 1, lat);
    check("post_reset_lat", lat, 3);

    for (int n = 0; n < 25; n++) begin
      resp_mode = $urandom_range(0, 2);
      rdy_mode  = 1;
      issue({$urandom, $urandom}, $urandom_range(0, 5), lat);
    end
    rdy_mode = 0;

    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/table_entry_fetcher.md
# table_entry_fetcher

Sequencer that drives the 8-lane DRAM port (user side) to read a run of consecutive 16-byte TABLE_ENTRY records from memory. It returns them one at a time as BUFFER_ENTRY words on a valid/ready stream. It sits between the field-table walker, which issues base address and count, and the shared DRAM port.

## Interface
- CNT_W, default 8: width of the entry-count field. Maximum run is 2^CNT_W-1 entries.
- clock, input, 1: single clock; all state updates on the rising edge.
- reset, input, 1: asynchronous, active-high; forces IDLE immediately.
- req_valid, input, 1: fetch request present.
- req_ready, output, 1: high only in IDLE; request accepted when req_valid && req_ready.
- req_addr, input, 64: byte address of the first entry. Must be 16-byte aligned; low 4 bits are ignored and treated as 0.
- req_count, input, CNT_W: number of entries to fetch.
- out_valid, output, 1: out_entry holds a complete entry.
- out_ready, input, 1: consumer accepts out_entry when out_valid && out_ready.
- out_entry, output, BUFFER_ENTRY (129): .valid=1 when out_valid, otherwise 0; .entry is the assembled TABLE_ENTRY.
- done, output, 1: one-cycle pulse when the run completes.
- dram, modport, DRAM_PORT.user: en/rdwr/addr driven; data read only, never driven (held 'z); valid sampled.

## Operation
- States:
  - IDLE: req_ready=1.
  - RD_LO: bytes 0-7 of the current entry.
  - RD_HI: bytes 8-15.
  - OUT: present the entry.
  - DONE: one cycle, done=1.
- Transitions:
  - IDLE → RD_LO on accept with req_count≠0. Latch cur_addr=req_addr with low 4 bits cleared, and remaining=req_count.
  - IDLE → DONE on accept with req_count=0. No DRAM traffic.
  - RD_LO → RD_HI in the cycle the last outstanding lane of beat 0 is captured.
  - RD_HI → OUT in the same manner for beat 1.
  - OUT → RD_LO on handshake when remaining-1≠0: cur_addr+=16 (64-bit wrap), remaining-=1.
  - OUT → DONE on handshake when remaining-1=0.
  - DONE → IDLE unconditionally.
- DRAM drive:
  - In RD_LO/RD_HI: en=8'hFF, rdwr=0 (read), addr[i]=cur_addr+i (RD_LO) or cur_addr+8+i (RD_HI).
  - In all other states: en=0, rdwr=0, addr=0.
- Lane capture:
  - Per-lane got[7:0] mask is cleared on entry to each RD state.
  - Lane i captures data[i] when valid[i] && !got[i] in an RD state.
  - valid[i] on an already-captured lane is ignored. Lanes may complete in any order and any cycle.
  - The beat completes when (got | valid) == 8'hFF.
- Byte mapping (little-endian): memory byte k of the entry (address cur_addr+k) maps to TABLE_ENTRY bits [8k+7:8k]. So nested_type_table is bytes 0-7, and field_id occupies bits [127:99].
- out_entry is registered and stable while out_valid is high. It is not modified until the handshake.
- No request is accepted outside IDLE; req_* is ignored there.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, out_valid=0, out_entry=0, done=0.
  - dram.en=0, dram.rdwr=0, dram.addr=0, got=0, cur_addr=0, remaining=0.
- Accept at edge T: en=8'hFF with beat-0 addresses from cycle T+1.
- If all 8 valid bits are high in the first RD_LO cycle, RD_HI follows next cycle. en stays high continuously; only addresses change.
- The beat-1 completion cycle is followed by out_valid=1 on the next cycle.
- Minimum latency, accept to out_valid, is 3 cycles with a same-cycle-valid DRAM.
- After an OUT handshake, the next entry's RD_LO is driven the following cycle (no bubble beyond OUT).
- done is asserted in the cycle after the final handshake. req_ready returns the cycle after done.
- Async reset mid-run: en drops immediately, and captured data and outstanding lanes are discarded. DRAM responses arriving after reset are ignored, because IDLE does not sample valid.

## Test plan
- Single entry: req_addr=0x1000, count=1, DRAM returns bytes equal to their address low byte, zero latency.
  - Beat 0 addr[i]=0x1000+i, then beat 1 addr[i]=0x1008+i.
  - out_entry.entry = {0x0F,0x0E,…,0x00} (byte k at bits [8k+7:8k]).
  - done 1 cycle after handshake.
- Ragged lanes: valid lanes arrive in order 7,0,3,…, one per cycle, with spurious repeat valid[7].
  - Beat completes only after the 8th distinct lane.
  - The repeat does not overwrite byte 7.
- Backpressure: count=3, out_ready low for 5 cycles on entry 2.
  - out_entry stable, en=0 during the stall.
  - Third entry fetched at addr+0x20.
  - Exactly 3 handshakes, one done.
- count=0: accept → done pulse on next cycle, en never asserted, req_ready high the cycle after done.
- Reset in RD_HI: en and out_valid drop asynchronously.
  - Late valid pulses are ignored.
  - A new request (addr 0x2F, treated as 0x20) then fetches correctly.
- Address wrap: req_addr=0xFFFF_FFFF_FFFF_FFF0, count=2. Second entry is read at 0x0…0 with lanes 0-15 addressed correctly.
